// File: rtl/mmio_router.sv
// MMIO decoder/router: maps core requests onto NDEV address windows and returns responses
// in order by tracking the target id of every in-flight request.
module mmio_router #(
    parameter int unsigned NDEV    = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MAX_OUT = 4,
    parameter logic [NDEV*ADDR_W-1:0] DEV_BASE =
        {32'hff000010, 32'hff000000, 32'hf8000000, 32'hf0000000},
    parameter logic [NDEV*ADDR_W-1:0] DEV_SIZE =
        {32'h00000010, 32'h00000004, 32'h00000018, 32'h00000010}
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic                   req_wen,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   resp_valid,
    output logic [DATA_W-1:0]      resp_rdata,
    output logic                   resp_error,
    output logic [NDEV-1:0]        dev_req_valid,
    input  logic [NDEV-1:0]        dev_req_ready,
    output logic [ADDR_W-1:0]      dev_addr,
    output logic                   dev_wen,
    output logic [DATA_W-1:0]      dev_wdata,
    input  logic [NDEV-1:0]        dev_resp_valid,
    input  logic [NDEV*DATA_W-1:0] dev_resp_rdata,
    output logic                   err_spurious
);

    localparam int unsigned ID_W  = $clog2(NDEV + 1);
    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [ID_W-1:0] ErrId = ID_W'(NDEV);

    logic [NDEV-1:0]   hit;
    logic [ADDR_W-1:0] dev_off [NDEV];

    // Window limit is ADDR_W+1 bits so a window ending at 2^ADDR_W does not wrap.
    for (genvar g = 0; g < NDEV; g++) begin : g_dec
        localparam logic [ADDR_W:0] Base = {1'b0, DEV_BASE[g*ADDR_W +: ADDR_W]};
        localparam logic [ADDR_W:0] Lim  = Base + {1'b0, DEV_SIZE[g*ADDR_W +: ADDR_W]};
        assign hit[g]     = ({1'b0, req_addr} >= Base) && ({1'b0, req_addr} < Lim);
        assign dev_off[g] = req_addr - Base[ADDR_W-1:0];
    end

    logic [ID_W-1:0]   target;
    logic [ADDR_W-1:0] offset;
    logic              tgt_ready;

    // Descending scan so the lowest matching index wins on overlap.
    always_comb begin
        target    = ErrId;
        offset    = req_addr;
        tgt_ready = 1'b1;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (hit[i]) begin
                target    = ID_W'(i);
                offset    = dev_off[i];
                tgt_ready = dev_req_ready[i];
            end
        end
    end

    logic [ID_W-1:0]  fifo_q [MAX_OUT];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ID_W-1:0]  last_id_q, last_id_d;
    logic             err_spurious_q, err_spurious_d;
    logic             empty, full, push, pop, spurious;
    logic [ID_W-1:0]  head;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(MAX_OUT));
    assign head  = fifo_q[rd_ptr_q];

    // A switch of target waits for the FIFO to drain; that alone keeps responses in order.
    assign req_ready = !full && (empty || last_id_q == target) && tgt_ready;
    assign push      = req_valid && req_ready;

    assign dev_addr     = offset;
    assign dev_wen      = req_wen;
    assign dev_wdata    = req_wdata;
    assign err_spurious = err_spurious_q;

    always_comb begin
        dev_req_valid = '0;
        for (int i = 0; i < NDEV; i++) begin
            dev_req_valid[i] = push && (target == ID_W'(i));
        end
    end

    always_comb begin
        resp_valid = 1'b0;
        resp_error = 1'b0;
        resp_rdata = '0;
        spurious   = 1'b0;
        if (!empty) begin
            if (head == ErrId) begin
                resp_valid = 1'b1;
                resp_error = 1'b1;
            end else begin
                for (int i = 0; i < NDEV; i++) begin
                    if (head == ID_W'(i)) begin
                        resp_valid = dev_resp_valid[i];
                        resp_rdata = dev_resp_rdata[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
        for (int j = 0; j < NDEV; j++) begin
            if (dev_resp_valid[j] && (empty || head != ID_W'(j))) spurious = 1'b1;
        end
    end

    assign pop = resp_valid;

    always_comb begin
        count_d        = count_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        last_id_d      = last_id_q;
        err_spurious_d = err_spurious_q | spurious;
        if (push && !pop) count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);
        if (push) begin
            wr_ptr_d  = (wr_ptr_q == PTR_W'(MAX_OUT - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            last_id_d = target;
        end
        if (pop) rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUT - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            last_id_q      <= ErrId;
            err_spurious_q <= 1'b0;
        end else begin
            count_q        <= count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            last_id_q      <= last_id_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    // Entries are only read while counted valid, so storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= target;
    end

endmodule
